// File: rtl/rv32i_types.sv
// Shared RV32I cache/memory types: cache line width and the default
// memory burst geometry used by the physical-memory burst adapter.
package rv32i_types;

  localparam int LINE_W         = 256;
  localparam int PMEM_BEAT_W    = 64;
  localparam int PMEM_NUM_BEATS = 4;

endpackage

// File: rtl/pmem_burst_adapter.sv
// Physical-memory burst adapter: converts one 256-bit cache line fill or
// writeback into a burst of NUM_BEATS memory beats of BEAT_W bits each.
// Optional feature macro: PMEM_TIMEOUT_EN enables a watchdog that aborts a
// burst after TIMEOUT_CYCLES consecutive cycles without resp_i and raises
// the sticky timeout_o flag.
module pmem_burst_adapter
  import rv32i_types::*;
#(
  parameter int BEAT_W         = PMEM_BEAT_W,
  parameter int NUM_BEATS      = PMEM_NUM_BEATS,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       address_i,
  input  logic              read_i,
  input  logic              write_i,
  input  logic [LINE_W-1:0] line_i,
  output logic [LINE_W-1:0] line_o,
  output logic              resp_o,
  input  logic [BEAT_W-1:0] burst_i,
  output logic [BEAT_W-1:0] burst_o,
  output logic [31:0]       address_o,
  output logic              read_o,
  output logic              write_o,
  input  logic              resp_i,
  output logic              timeout_o
);

  localparam int CNT_W = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RD_BURST,
    WR_BURST,
    DONE
  } state_e;

  state_e            r_state;
  state_e            w_next;
  logic [CNT_W-1:0]  r_beat;
  logic [LINE_W-1:0] r_line;
  logic [LINE_W-1:0] r_wline;
  logic [31:0]       r_addr;
  logic              w_in_burst;
  logic              w_last;
  logic              w_abort;

  assign w_in_burst = (r_state == RD_BURST) || (r_state == WR_BURST);
  assign w_last     = (r_beat == LAST_BEAT);

`ifdef PMEM_TIMEOUT_EN
  localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WDOG_W-1:0] r_wdog;
  logic              r_timeout;

  // The cycle that would make the idle run reach TIMEOUT_CYCLES aborts the burst.
  assign w_abort = w_in_burst && !resp_i && (r_wdog == WDOG_W'(TIMEOUT_CYCLES - 1));

  // Watchdog: counts consecutive burst cycles with no beat; sticky error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wdog    <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_in_burst && !resp_i && !w_abort) begin
        r_wdog <= r_wdog + 1'b1;
      end else begin
        r_wdog <= '0;
      end
      if (w_abort) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign timeout_o = r_timeout;
`else
  assign w_abort = 1'b0;
  // Watchdog compiled out: the flag is constant low. TIMEOUT_CYCLES is only
  // referenced so the parameter remains part of the interface in this build.
  assign timeout_o = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and strobe decode; writes win over reads when both are requested.
  always_comb begin
    w_next  = r_state;
    read_o  = 1'b0;
    write_o = 1'b0;
    resp_o  = 1'b0;
    case (r_state)
      IDLE: begin
        if (write_i) begin
          w_next = WR_BURST;
        end else if (read_i) begin
          w_next = RD_BURST;
        end
      end
      RD_BURST: begin
        read_o = 1'b1;
        if ((resp_i && w_last) || w_abort) begin
          w_next = DONE;
        end
      end
      WR_BURST: begin
        write_o = 1'b1;
        if ((resp_i && w_last) || w_abort) begin
          w_next = DONE;
        end
      end
      DONE: begin
        resp_o = 1'b1;
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Request latch, beat counter and fill-line assembly; the counter holds on gaps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_beat  <= '0;
      r_line  <= '0;
      r_wline <= '0;
      r_addr  <= '0;
    end else begin
      if (r_state == IDLE) begin
        r_beat <= '0;
        if (write_i || read_i) begin
          r_addr <= address_i & ~32'h0000_001F;
        end
        if (write_i) begin
          r_wline <= line_i;
        end
      end else if (w_in_burst) begin
        if (resp_i) begin
          if (r_state == RD_BURST) begin
            r_line[int'(r_beat)*BEAT_W +: BEAT_W] <= burst_i;
          end
          r_beat <= w_last ? '0 : r_beat + 1'b1;
        end else if (w_abort) begin
          r_beat <= '0;
        end
      end
    end
  end

  assign line_o    = r_line;
  assign address_o = r_addr;
  assign burst_o   = (r_state == WR_BURST) ? r_wline[int'(r_beat)*BEAT_W +: BEAT_W] : '0;

endmodule

// File: tb/tb_pmem_burst_adapter.sv
// Testbench for pmem_burst_adapter: directed cache/memory transactions with a
// transaction-level reference model checked on every falling clock edge.
module tb_pmem_burst_adapter;

  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;
  logic         timeout_o;

  int n_tests = 0;
  int n_fail  = 0;
  int cnt_rd   = 0;
  int cnt_wr   = 0;
  int cnt_resp = 0;

  // Reference model state: op 0 = none, 1 = line fill, 2 = writeback.
  int           m_op;
  int           m_nb;
  int           m_gap;
  bit           m_resp;
  bit           m_to;
  logic [31:0]  m_addr;
  logic [255:0] m_line;
  logic [255:0] m_wline;

  localparam logic [255:0] LINE_A =
    256'hDDDD_0004_DDDD_0004_CCCC_0003_CCCC_0003_BBBB_0002_BBBB_0002_AAAA_0001_AAAA_0001;
  localparam logic [255:0] LINE_W =
    256'h3123_4567_89AB_CDEF_2123_4567_89AB_CDEF_1123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
  localparam logic [255:0] LINE_X =
    256'hFEED_FACE_0000_0003_FEED_FACE_0000_0002_FEED_FACE_0000_0001_FEED_FACE_0000_0000;
  localparam logic [255:0] LINE_B =
    256'h4444_4444_4444_4444_3333_3333_3333_3333_2222_2222_2222_2222_1111_1111_1111_1111;

  always #5 clk = ~clk;

  pmem_burst_adapter #(
    .BEAT_W(64),
    .NUM_BEATS(4),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .address_i(address_i),
    .read_i(read_i),
    .write_i(write_i),
    .line_i(line_i),
    .line_o(line_o),
    .resp_o(resp_o),
    .burst_i(burst_i),
    .burst_o(burst_o),
    .address_o(address_o),
    .read_o(read_o),
    .write_o(write_o),
    .resp_i(resp_i),
    .timeout_o(timeout_o)
  );

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Transaction model: one request at a time, four beats, then one response cycle.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_op    <= 0;
      m_nb    <= 0;
      m_gap   <= 0;
      m_resp  <= 1'b0;
      m_to    <= 1'b0;
      m_addr  <= '0;
      m_line  <= '0;
      m_wline <= '0;
    end else if (m_resp) begin
      m_resp <= 1'b0;
    end else if (m_op == 0) begin
      if (write_i) begin
        m_op    <= 2;
        m_nb    <= 0;
        m_gap   <= 0;
        m_addr  <= {address_i[31:5], 5'b0};
        m_wline <= line_i;
      end else if (read_i) begin
        m_op   <= 1;
        m_nb   <= 0;
        m_gap  <= 0;
        m_addr <= {address_i[31:5], 5'b0};
      end
    end else if (resp_i) begin
      m_gap <= 0;
      if (m_op == 1) m_line[m_nb*64 +: 64] <= burst_i;
      if (m_nb == 3) begin
        m_op   <= 0;
        m_resp <= 1'b1;
      end else begin
        m_nb <= m_nb + 1;
      end
    end else begin
`ifdef PMEM_TIMEOUT_EN
      if (m_gap + 1 == TO) begin
        m_op   <= 0;
        m_resp <= 1'b1;
        m_to   <= 1'b1;
      end else begin
        m_gap <= m_gap + 1;
      end
`endif
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    chk("read_o", 256'(read_o), 256'(m_op == 1));
    chk("write_o", 256'(write_o), 256'(m_op == 2));
    chk("resp_o", 256'(resp_o), 256'(m_resp));
    chk("address_o", 256'(address_o), 256'(m_addr));
    chk("line_o", line_o, m_line);
    chk("burst_o", 256'(burst_o), 256'((m_op == 2) ? m_wline[m_nb*64 +: 64] : 64'h0));
    chk("timeout_o", 256'(timeout_o), 256'(m_to));
    chk("strobes exclusive", 256'(read_o & write_o), 256'(0));
    if (read_o)  cnt_rd++;
    if (write_o) cnt_wr++;
    if (resp_o)  cnt_resp++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Request must already be on the inputs; plays the memory side of one burst.
  task automatic serve(input bit is_rd, input logic [255:0] data, input int gap,
                       output int lat, output logic [255:0] seen);
    lat  = 0;
    seen = '0;
    @(posedge clk); lat++; #1;
    for (int b = 0; b < 4; b++) begin
      if (b > 0) begin
        for (int g = 0; g < gap; g++) begin
          resp_i  = 1'b0;
          burst_i = '0;
          @(posedge clk); lat++; #1;
        end
      end
      resp_i = 1'b1;
      if (is_rd) burst_i = data[b*64 +: 64];
      else seen[b*64 +: 64] = burst_o;
      @(posedge clk); lat++; #1;
    end
    resp_i  = 1'b0;
    burst_i = '0;
    read_i  = 1'b0;
    write_i = 1'b0;
    chk("resp_o after last beat", 256'(resp_o), 256'(1));
  endtask

  initial begin
    int           lat;
    logic [255:0] seen;
    rst       = 1'b0;
    address_i = '0;
    read_i    = 1'b0;
    write_i   = 1'b0;
    line_i    = '0;
    burst_i   = '0;
    resp_i    = 1'b0;
    repeat (3) tick();
    chk("reset address_o", 256'(address_o), 256'(0));
    chk("reset line_o", line_o, 256'(0));
    chk("reset strobes", 256'({read_o, write_o, resp_o, timeout_o}), 256'(0));
    chk("reset burst_o", 256'(burst_o), 256'(0));
    rst = 1'b1;
    tick();

    // Line fill, back-to-back beats.
    address_i = 32'h0000_1234;
    read_i    = 1'b1;
    cnt_resp  = 0;
    serve(1'b1, LINE_A, 0, lat, seen);
    chk("read latency", 256'(lat), 256'(5));
    chk("read address_o", 256'(address_o), 256'(32'h0000_1220));
    chk("read line_o", line_o, LINE_A);
    chk("read beat A in low slot", 256'(line_o[63:0]), 256'(64'hAAAA_0001_AAAA_0001));
    tick();
    chk("resp_o single cycle", 256'(resp_o), 256'(0));
    chk("read resp count", 256'(cnt_resp), 256'(1));

    // Writeback with one-cycle gaps between beats.
    address_i = 32'h8000_0040;
    write_i   = 1'b1;
    line_i    = LINE_W;
    cnt_wr    = 0;
    cnt_resp  = 0;
    serve(1'b0, LINE_W, 1, lat, seen);
    chk("write latency", 256'(lat), 256'(8));
    chk("write beat 0", 256'(seen[63:0]), 256'(64'h0123_4567_89AB_CDEF));
    chk("write beat 3", 256'(seen[255:192]), 256'(64'h3123_4567_89AB_CDEF));
    chk("write beats order", seen, LINE_W);
    chk("write address_o", 256'(address_o), 256'(32'h8000_0040));
    tick();
    chk("write_o cycles", 256'(cnt_wr), 256'(7));
    chk("write resp count", 256'(cnt_resp), 256'(1));
    chk("line_o untouched by write", line_o, LINE_A);

    // Simultaneous read and write: only the write is serviced.
    address_i = 32'h0000_0FFF;
    read_i    = 1'b1;
    write_i   = 1'b1;
    line_i    = LINE_X;
    cnt_rd    = 0;
    cnt_wr    = 0;
    serve(1'b0, LINE_X, 0, lat, seen);
    chk("priority write beats", seen, LINE_X);
    chk("priority address_o", 256'(address_o), 256'(32'h0000_0FE0));
    tick();
    chk("priority read_o never", 256'(cnt_rd), 256'(0));
    chk("priority write_o cycles", 256'(cnt_wr), 256'(4));

    // Reset in the middle of a fill, then a clean fill right after release.
    address_i = 32'h2000_0011;
    read_i    = 1'b1;
    tick();
    for (int b = 0; b < 3; b++) begin
      resp_i  = 1'b1;
      burst_i = LINE_B[b*64 +: 64];
      tick();
    end
    resp_i  = 1'b0;
    burst_i = '0;
    read_i  = 1'b0;
    rst     = 1'b0;
    #1;
    chk("midburst reset line_o", line_o, 256'(0));
    chk("midburst reset address_o", 256'(address_o), 256'(0));
    chk("midburst reset strobes", 256'({read_o, write_o, resp_o, timeout_o}), 256'(0));
    chk("midburst reset burst_o", 256'(burst_o), 256'(0));
    repeat (2) tick();
    rst       = 1'b1;
    address_i = 32'h3000_0000;
    read_i    = 1'b1;
    serve(1'b1, LINE_B, 0, lat, seen);
    chk("post-reset read latency", 256'(lat), 256'(5));
    chk("post-reset read line_o", line_o, LINE_B);
    chk("post-reset address_o", 256'(address_o), 256'(32'h3000_0000));
    tick();

`ifdef PMEM_TIMEOUT_EN
    // Memory never answers: watchdog abort and sticky flag.
    address_i = 32'h0000_0100;
    read_i    = 1'b1;
    lat       = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); lat++; #1;
      if (resp_o) break;
    end
    read_i = 1'b0;
    chk("timeout abort latency", 256'(lat), 256'(TO + 1));
    chk("timeout_o set", 256'(timeout_o), 256'(1));
    repeat (3) tick();
    chk("timeout_o sticky", 256'(timeout_o), 256'(1));
    rst = 1'b0;
    #1;
    chk("timeout_o cleared by reset", 256'(timeout_o), 256'(0));
    tick();
    rst = 1'b1;
`else
    chk("timeout_o tied low", 256'(timeout_o), 256'(0));
`endif

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
